fibo_job_scheduler: RTL and testbench

Shared Fibonacci compute engine with a round-robin front end. Up to NREQ requesters each submit a term index n; the scheduler grants one job at a time, sequences an internal iterative two-register adder datapath to produce F(n), and returns the result tagged with the requester ID over a valid/ready response channel. It sits between several control agents and a single series datapath, so the agents never run the adder concurrently.

---
 rtl/fibo_job_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fibo_job_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_job_scheduler.sv
// Round-robin front end sharing one iterative Fibonacci adder among NREQ requesters.
// Define FIBO_OVF_EN to saturate results that exceed WIDTH and report them on rsp_ovf.
module fibo_job_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int NW    = 8,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*NW-1:0]   req_n,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [WIDTH-1:0]     rsp_value,
    output logic                 rsp_ovf,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a request, arbiter live
    // RUN   | iterating a/b until cnt reaches n
    // DONE  | result presented until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     rr_ptr, id_r;
    logic [NW-1:0]     n_r;
    logic [NW:0]       cnt;
    logic [WIDTH-1:0]  a, b, val_r;

    logic [2*NREQ-1:0] dbl_shift;
    logic [NREQ-1:0]   rot;
    logic [IW-1:0]     gnt_off, gnt_idx, ptr_nxt;
    logic [IW:0]       idx_sum;
    logic              gnt_any;
    logic [NW-1:0]     req_n_sel;

    logic              accept, finish, rsp_hs;

    // Rotate the request vector so bit 0 is the requester at rr_ptr.
    always_comb begin
        dbl_shift = {req_valid, req_valid} >> rr_ptr;
        rot       = dbl_shift[NREQ-1:0];
        gnt_any   = 1'b0;
        gnt_off   = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                gnt_off = IW'(k);
            end
        end
        idx_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (idx_sum >= (IW+1)'(NREQ))
            idx_sum = idx_sum - (IW+1)'(NREQ);
        gnt_idx = idx_sum[IW-1:0];
        if (gnt_idx == IW'(NREQ-1))
            ptr_nxt = '0;
        else
            ptr_nxt = gnt_idx + IW'(1);
        req_n_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i))
                req_n_sel = req_n[i*NW +: NW];
        end
    end

    assign accept = (state == IDLE) && gnt_any;
    assign finish = (state == RUN) && (cnt == {1'b0, n_r});
    assign rsp_hs = (state == DONE) && rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIBO_OVF_EN
    logic [WIDTH:0] sum;
    logic           ovf_a, ovf_b, ovf_b_nxt, ovf_r;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign ovf_b_nxt = ovf_a | ovf_b | sum[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (finish) begin
            ovf_r <= ovf_a;
        end else if (state == RUN) begin
            ovf_a <= ovf_b;
            ovf_b <= ovf_b_nxt;
        end
    end

    assign rsp_ovf = ovf_r;
`else
    logic [WIDTH-1:0] sum;

    assign sum     = a + b;
    assign rsp_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            id_r   <= '0;
            n_r    <= '0;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            val_r  <= '0;
        end else if (accept) begin
            rr_ptr <= ptr_nxt;
            id_r   <= gnt_idx;
            n_r    <= req_n_sel;
            cnt    <= '0;
            a      <= '0;
            b      <= WIDTH'(1);
        end else if (finish) begin
`ifdef FIBO_OVF_EN
            val_r  <= ovf_a ? '1 : a;
`else
            val_r  <= a;
`endif
        end else if (state == RUN) begin
            a      <= b;
`ifdef FIBO_OVF_EN
            // Once the upper term has overflowed it pins at all-ones.
            b      <= ovf_b_nxt ? '1 : sum[WIDTH-1:0];
`else
            b      <= sum;
`endif
            cnt    <= cnt + (NW+1)'(1);
        end
    end

    // Gated by reset so a pending request cannot show a strobe while reset is held.
    assign req_ready = (accept && !reset) ? (NREQ'(1) << gnt_idx) : '0;
    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_r;
    assign rsp_value = val_r;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// Randomised and directed checks of fibo_job_scheduler against a wide-integer Fibonacci
// and round-robin reference model.
`timescale 1ns/1ps
module tb_fibo_job_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int NW    = 8;
    localparam int IW    = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*NW-1:0]  req_n = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IW-1:0]       rsp_id;
    logic [WIDTH-1:0]    rsp_value;
    logic                rsp_ovf;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;
    int ptr_m = 0;
    int g;

    always #5 clk = ~clk;

    fibo_job_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .NW(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact Fibonacci in a wide integer, then reduced to WIDTH bits.
    function automatic logic [WIDTH:0] ref_fib(input int n);
        logic [191:0] x, y, t;
        x = '0;
        y = 192'd1;
        for (int k = 0; k < n; k++) begin
            t = x + y;
            x = y;
            y = t;
        end
`ifdef FIBO_OVF_EN
        if (x[191:WIDTH] != '0)
            return {1'b1, {WIDTH{1'b1}}};
`endif
        return {1'b0, x[WIDTH-1:0]};
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        return -1;
    endfunction

    task automatic serve(input int hold, output int gid);
        int eg, cyc, n, busy_low;
        logic [WIDTH:0] r;
        #1;
        eg  = ref_grant();
        gid = eg;
        if (eg < 0) begin
            check("grant_none", req_ready, 0);
            return;
        end
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("grant", req_ready, 4'b0001 << eg);
        n = int'(req_n[eg*NW +: NW]);
        r = ref_fib(n);
        ptr_m = (eg + 1) % NREQ;
        tick();
        req_valid[eg] = 1'b0;
        check("ready_in_run", req_ready, 0);
        cyc = 0;
        busy_low = 0;
        while (!rsp_valid && cyc < n + 4) begin
            if (!busy) busy_low++;
            tick();
            cyc++;
        end
        check("latency", cyc, n + 1);
        check("busy_run", busy_low, 0);
        check("busy_done", busy, 1);
        check("value", rsp_value, r[WIDTH-1:0]);
        check("ovf", rsp_ovf, r[WIDTH]);
        check("id", rsp_id, eg);
        if (hold > 0) begin
            rsp_ready = 1'b0;
            repeat (hold) begin
                tick();
                check("hold_valid", rsp_valid, 1);
                check("hold_value", rsp_value, r[WIDTH-1:0]);
                check("hold_noready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        tick();
        check("valid_drop", rsp_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_value", rsp_value, 0);
        check("rst_id", rsp_id, 0);
        check("rst_ovf", rsp_ovf, 0);
        reset = 1'b0;
        tick();

        // Contention: n = 1..4 on all requesters, pointer at 0.
        for (int i = 0; i < NREQ; i++) req_n[i*NW +: NW] = NW'(i + 1);
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            serve(0, g);
            check("rr_order", g, i);
        end
        req_n[0 +: NW] = 8'd6;
        req_n[3*NW +: NW] = 8'd7;
        req_valid = 4'b1001;
        serve(0, g);
        check("rr_rereq0", g, 0);
        serve(0, g);
        check("rr_rereq3", g, 3);

        // F(0) on requester 0, F(10) on requester 2.
        req_n[0 +: NW] = 8'd0;
        req_valid = 4'b0001;
        serve(0, g);
        req_n[2*NW +: NW] = 8'd10;
        req_valid = 4'b0100;
        serve(0, g);
        check("f10_id", g, 2);

        // Backpressure with requester 1 waiting.
        req_n[3*NW +: NW] = 8'd5;
        req_n[1*NW +: NW] = 8'd7;
        req_valid = 4'b1010;
        serve(6, g);
        check("bp_id", g, 3);
        check("rdy_after_hs", req_ready, 4'b0010);
        serve(0, g);

        // Overflow boundary.
        req_n[0 +: NW] = 8'd47;
        req_valid = 4'b0001;
        serve(0, g);
        req_n[0 +: NW] = 8'd48;
        req_valid = 4'b0001;
        serve(0, g);
        req_n[0 +: NW] = 8'd255;
        req_valid = 4'b0001;
        serve(0, g);

        // Reset in the middle of a job on requester 2.
        req_n[2*NW +: NW] = 8'd20;
        req_valid = 4'b0100;
        #1;
        check("mid_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b1010;
        req_n[1*NW +: NW] = 8'd3;
        req_n[3*NW +: NW] = 8'd4;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_value", rsp_value, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_ovf", rsp_ovf, 0);
        tick();
        reset = 1'b0;
        ptr_m = 0;
        serve(0, g);
        check("post_rst_first", g, 1);
        serve(0, g);
        check("post_rst_second", g, 3);

        // Random traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_n[i*NW +: NW] = ($urandom_range(0, 9) == 0) ? NW'($urandom_range(0, 255))
                                                                    : NW'($urandom_range(0, 50));
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid != '0) serve($urandom_range(0, 3), g);
        end
        while (req_valid != '0) serve(0, g);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
